vpu_stream_ctrl: RTL and testbench
==================================

Name: vpu_stream_ctrl

Overview:
- Command-driven sequencer that sits directly upstream and downstream of `vpu_op`.
- Accepts one vector command, streams operand pairs from two synchronous vector buffers into `vpu_op`, and writes each result to a destination buffer.
- Signals completion per command.
- Converts the combinational ALU into a pipelined, one-element-per-cycle vector engine.

Parameters:
- DATA_W, 32, element width (FP32).
- OP_W, 4, opcode width; must match `vpu_op`.
- ADDR_W, 10, buffer address width.
- LEN_W, 11, vector length width; allows lengths 0..2^ADDR_W.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  command can be accepted; high only in IDLE.
- cmd_opcode  input  OP_W  0=ADD, 1=SUB, 2=MULT_CONST.
- cmd_src_a  input  ADDR_W  base address, buffer A.
- cmd_src_b  input  ADDR_W  base address, buffer B; ignored for MULT_CONST.
- cmd_dst  input  ADDR_W  base address, destination buffer.
- cmd_len  input  LEN_W  element count.
- cmd_scalar  input  DATA_W  constant operand for MULT_CONST.
- rd_en_a, rd_en_b  output  1  read strobes.
- rd_addr_a, rd_addr_b  output  ADDR_W  read addresses.
- rd_data_a, rd_data_b  input  DATA_W  read data, valid exactly 1 cycle after the strobe.
- op_start  output  1  drives `vpu_op` start.
- op_operand0, op_operand1  output  DATA_W  drive `vpu_op` operands.
- op_opcode  output  OP_W  drives `vpu_op` opcode.
- op_result  input  DATA_W  combinational result from `vpu_op`.
- wr_en  output  1  destination write strobe.
- wr_addr  output  ADDR_W  destination address.
- wr_data  output  DATA_W  destination data.
- busy  output  1  high whenever the FSM is not in IDLE.
- done  output  1  one-cycle completion pulse.
- err  output  1  one-cycle pulse, coincident with done, for an illegal opcode.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE; cmd_ready=1.
  - All other outputs 0: rd_en_*, wr_en, op_start, busy, done, err, addresses, data, op_* buses.
  - Reset mid-command abandons it immediately; no further reads or writes are issued after rst_n deasserts.
- FSM states: IDLE, ISSUE, DRAIN, FIN.
- IDLE:
  - Accept when cmd_valid && cmd_ready (cycle 0); latch all cmd_* fields.
  - Opcode > 2 → FIN with err set.
  - cmd_len=0 → FIN.
  - Otherwise → ISSUE.
- ISSUE, cycles 1..len:
  - rd_en_a=1, rd_addr_a=src_a+i for i=0..len-1.
  - For ADD/SUB: rd_en_b=1, rd_addr_b=src_b+i.
  - For MULT_CONST: rd_en_b=0.
  - After the last strobe → DRAIN.
- Execute stage (cycle i+2):
  - op_start=1, op_operand0=rd_data_a, op_opcode=latched opcode.
  - op_operand1=rd_data_b, or the latched scalar for MULT_CONST.
  - op_start=0 and op_* buses held at 0 when no element is in this stage.
- Write stage (cycle i+3): registered wr_en=1, wr_addr=dst+i, wr_data=op_result captured in the previous cycle.
- DRAIN: wait until the last write issues (cycle len+2), then → FIN.
- FIN: done=1 for one cycle, err as latched, then → IDLE. cmd_ready is 1 again on the following cycle.
- Timing consequences:
  - Throughput is 1 element/cycle with no bubbles.
  - Last wr_en is at cycle len+2; done is at cycle len+3.
  - For len=0 or an illegal opcode: done at cycle 1, with no reads or writes.
- Address arithmetic is modulo 2^ADDR_W; wrap past max address is silent.
- cmd_valid while busy is ignored (not latched); no command queueing.
- Overlapping buffer ranges are not detected; read-after-write hazards are the caller's responsibility.

Test Plan:
- ADD, len=4, src_a=0, src_b=16, dst=32, A={1.0,2.0,3.0,4.0}, B={0.5,0.5,0.5,0.5} → wr_en at cycles 3..6, addr 32..35, data {1.5,2.5,3.5,4.5}; done at cycle 7.
- SUB, len=2, A={3.0,1.0}, B={1.0,2.0} → writes {2.0,-1.0}; rd_en_b high cycles 1–2.
- MULT_CONST, len=3, scalar=2.0, A={1.0,-1.5,0.0} → op_operand1=2.0 on every op_start; rd_en_b never asserted; writes {2.0,-3.0,0.0}.
- cmd_len=0, then cmd_opcode=7 → both produce done at cycle 1, no rd_en/wr_en; err=1 only for opcode 7.
- Wrap: src_a=1022, dst=1023, len=3 (ADDR_W=10) → rd_addr_a 1022,1023,0; wr_addr 1023,0,1.
- rst_n pulled low at cycle 3 of a len=8 ADD → all outputs 0 asynchronously; no wr_en after release; cmd_ready=1 and a new command is accepted normally.

Source files
------------

// File: rtl/vpu_stream_ctrl.sv
// Command sequencer wrapping the combinational vpu_op ALU.
// Streams buffer reads -> execute -> registered write, one element per cycle.
module vpu_stream_ctrl #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4,
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_opcode,
  input  logic [ADDR_W-1:0] cmd_src_a,
  input  logic [ADDR_W-1:0] cmd_src_b,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_scalar,
  output logic              rd_en_a,
  output logic              rd_en_b,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  input  logic [DATA_W-1:0] rd_data_a,
  input  logic [DATA_W-1:0] rd_data_b,
  output logic              op_start,
  output logic [DATA_W-1:0] op_operand0,
  output logic [DATA_W-1:0] op_operand1,
  output logic [OP_W-1:0]   op_opcode,
  input  logic [DATA_W-1:0] op_result,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [OP_W-1:0] OP_MUL = OP_W'(2);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  state_t            state_q, state_d;
  logic [OP_W-1:0]   opc_q, opc_d;
  logic [ADDR_W-1:0] src_a_q, src_a_d;
  logic [ADDR_W-1:0] src_b_q, src_b_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [DATA_W-1:0] scalar_q, scalar_d;
  logic              err_q, err_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic              ex_vld_q, ex_vld_d;
  logic [ADDR_W-1:0] ex_idx_q, ex_idx_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic issue;
  logic is_mul;

  assign issue  = (state_q == ISSUE);
  assign is_mul = (opc_q == OP_MUL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      opc_q     <= '0;
      src_a_q   <= '0;
      src_b_q   <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      scalar_q  <= '0;
      err_q     <= 1'b0;
      idx_q     <= '0;
      ex_vld_q  <= 1'b0;
      ex_idx_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      opc_q     <= opc_d;
      src_a_q   <= src_a_d;
      src_b_q   <= src_b_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      scalar_q  <= scalar_d;
      err_q     <= err_d;
      idx_q     <= idx_d;
      ex_vld_q  <= ex_vld_d;
      ex_idx_q  <= ex_idx_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    opc_d    = opc_q;
    src_a_d  = src_a_q;
    src_b_d  = src_b_q;
    dst_d    = dst_q;
    len_d    = len_q;
    scalar_d = scalar_q;
    err_d    = err_q;
    idx_d    = idx_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          opc_d    = cmd_opcode;
          src_a_d  = cmd_src_a;
          src_b_d  = cmd_src_b;
          dst_d    = cmd_dst;
          len_d    = cmd_len;
          scalar_d = cmd_scalar;
          idx_d    = '0;
          err_d    = (cmd_opcode > OP_MUL);
          if (cmd_opcode > OP_MUL || cmd_len == '0)
            state_d = FIN;
          else
            state_d = ISSUE;
        end
      end
      ISSUE: begin
        idx_d = idx_q + LEN_W'(1);
        if (idx_q == len_q - LEN_W'(1))
          state_d = DRAIN;
      end
      DRAIN: begin
        // last element has left execute; its write is on the bus now
        if (!ex_vld_q)
          state_d = FIN;
      end
      FIN: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ex_vld_d  = issue;
    ex_idx_d  = issue ? idx_q[ADDR_W-1:0] : '0;
    wr_en_d   = ex_vld_q;
    wr_addr_d = ex_vld_q ? dst_q + ex_idx_q : '0;
    wr_data_d = ex_vld_q ? op_result : '0;
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);
  assign err       = done & err_q;

  assign rd_en_a   = issue;
  assign rd_en_b   = issue & ~is_mul;
  assign rd_addr_a = rd_en_a ? src_a_q + idx_q[ADDR_W-1:0] : '0;
  assign rd_addr_b = rd_en_b ? src_b_q + idx_q[ADDR_W-1:0] : '0;

  assign op_start    = ex_vld_q;
  assign op_opcode   = ex_vld_q ? opc_q : '0;
  assign op_operand0 = ex_vld_q ? rd_data_a : '0;
  assign op_operand1 = !ex_vld_q ? '0 : (is_mul ? scalar_q : rd_data_b);

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_vpu_stream_ctrl.sv
// Bench for vpu_stream_ctrl: buffer and ALU models, vector table,
// write/read scoreboards and a mid-command reset sequence.
module tb_vpu_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_opcode = '0;
  logic [9:0]  cmd_src_a = '0, cmd_src_b = '0, cmd_dst = '0;
  logic [10:0] cmd_len = '0;
  logic [31:0] cmd_scalar = '0;
  logic        rd_en_a, rd_en_b;
  logic [9:0]  rd_addr_a, rd_addr_b;
  logic [31:0] rd_data_a = '0, rd_data_b = '0;
  logic        op_start;
  logic [31:0] op_operand0, op_operand1, op_result;
  logic [3:0]  op_opcode;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy, done, err;

  logic [31:0] mem_a [1024];
  logic [31:0] mem_b [1024];

  int checks = 0;
  int errors = 0;

  vpu_stream_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_src_a(cmd_src_a),
    .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst),
    .cmd_len(cmd_len), .cmd_scalar(cmd_scalar),
    .rd_en_a(rd_en_a), .rd_en_b(rd_en_b),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .op_start(op_start), .op_operand0(op_operand0),
    .op_operand1(op_operand1), .op_opcode(op_opcode),
    .op_result(op_result),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rd_data_a <= rd_en_a ? mem_a[rd_addr_a] : 32'hDEAD_BEEF;
    rd_data_b <= rd_en_b ? mem_b[rd_addr_b] : 32'hDEAD_BEEF;
  end

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    logic [10:0] e;
    e = 11'({3'b0, f[30:23]}) + 11'd896;
    d = (f[30:0] == '0) ? {f[31], 63'b0} : {f[31], e, f[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return (d[62:0] == '0) ? {d[63], 31'b0} : {d[63], e[7:0], d[51:29]};
  endfunction

  // stand-in for vpu_op
  always_comb begin
    op_result = '0;
    case (op_opcode)
      4'd0: op_result = r2f(f2r(op_operand0) + f2r(op_operand1));
      4'd1: op_result = r2f(f2r(op_operand0) - f2r(op_operand1));
      4'd2: op_result = r2f(f2r(op_operand0) * f2r(op_operand1));
      default: op_result = '0;
    endcase
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0]       opc;
    logic [9:0]       sa;
    logic [9:0]       sb;
    logic [9:0]       dst;
    logic [10:0]      len;
    logic [31:0]      scalar;
    logic [3:0][31:0] a;
    logic [3:0][31:0] b;
    logic [3:0][31:0] exp;
    logic             exp_err;
    int               exp_done;
  } vec_t;

  localparam logic [31:0] F0_5 = 32'h3F00_0000;
  localparam logic [31:0] F1   = 32'h3F80_0000;
  localparam logic [31:0] F1_5 = 32'h3FC0_0000;
  localparam logic [31:0] F2   = 32'h4000_0000;
  localparam logic [31:0] F2_5 = 32'h4020_0000;
  localparam logic [31:0] F3   = 32'h4040_0000;
  localparam logic [31:0] F3_5 = 32'h4060_0000;
  localparam logic [31:0] F4   = 32'h4080_0000;
  localparam logic [31:0] F4_5 = 32'h4090_0000;
  localparam logic [31:0] FM1  = 32'hBF80_0000;
  localparam logic [31:0] FM15 = 32'hBFC0_0000;
  localparam logic [31:0] FM3  = 32'hC040_0000;

  logic [9:0]  rdq_a[$];
  logic [9:0]  rdq_b[$];
  logic [41:0] wrq[$];

  task automatic chk_rst(input string nm);
    chk({nm, "_ctl"},
        {cmd_ready, rd_en_a, rd_en_b, op_start, wr_en, busy, done, err},
        8'b1000_0000);
    chk({nm, "_addr"}, {rd_addr_a, rd_addr_b, wr_addr}, '0);
    chk({nm, "_ops"}, {op_operand0, op_operand1}, '0);
    chk({nm, "_wdat"}, {op_opcode, wr_data}, '0);
  endtask

  task automatic drive_cmd(input vec_t v);
    @(negedge clk);
    chk("cmd_ready", cmd_ready, 1'b1);
    cmd_valid  = 1'b1;
    cmd_opcode = v.opc;
    cmd_src_a  = v.sa;
    cmd_src_b  = v.sb;
    cmd_dst    = v.dst;
    cmd_len    = v.len;
    cmd_scalar = v.scalar;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic run(input vec_t v);
    int done_cyc, first_wr, rdb, bad1, extra;
    logic err_seen;
    logic [41:0] w;
    logic legal;
    legal = (v.opc <= 4'd2) && (v.len != '0);
    done_cyc = -1; first_wr = -1; rdb = 0; bad1 = 0; extra = 0;
    err_seen = 1'b0;
    rdq_a.delete(); rdq_b.delete(); wrq.delete();
    for (int i = 0; i < int'(v.len); i++) begin
      mem_a[10'(v.sa + 10'(i))] = v.a[i];
      mem_b[10'(v.sb + 10'(i))] = v.b[i];
      if (legal) begin
        rdq_a.push_back(10'(v.sa + 10'(i)));
        if (v.opc != 4'd2) rdq_b.push_back(10'(v.sb + 10'(i)));
        wrq.push_back({10'(v.dst + 10'(i)), v.exp[i]});
      end
    end
    drive_cmd(v);
    for (int cyc = 1; cyc <= 60 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      if (rd_en_a) begin
        if (rdq_a.size() == 0) extra++;
        else chk("rd_addr_a", rd_addr_a, rdq_a.pop_front());
      end
      if (rd_en_b) begin
        rdb++;
        if (rdq_b.size() == 0) extra++;
        else chk("rd_addr_b", rd_addr_b, rdq_b.pop_front());
      end
      if (op_start && v.opc == 4'd2 && op_operand1 !== v.scalar) bad1++;
      if (wr_en) begin
        if (first_wr < 0) first_wr = cyc;
        if (wrq.size() == 0) extra++;
        else begin
          w = wrq.pop_front();
          chk("wr_addr", wr_addr, w[41:32]);
          chk("wr_data", wr_data, w[31:0]);
        end
      end
      if (done) begin
        done_cyc = cyc;
        err_seen = err;
      end
    end
    chk("done_cyc", done_cyc, v.exp_done);
    chk("err", err_seen, v.exp_err);
    chk("extra_rw", extra, 0);
    chk("left", rdq_a.size() + rdq_b.size() + wrq.size(), 0);
    chk("rdb_cnt", rdb, (legal && v.opc != 4'd2) ? int'(v.len) : 0);
    if (legal) chk("first_wr", first_wr, 3);
    if (v.opc == 4'd2) chk("mul_opnd1", bad1, 0);
    @(negedge clk);
    chk("ready_after", {cmd_ready, busy, done}, 3'b100);
  endtask

  vec_t tbl [6];

  initial begin
    int act;
    vec_t r;
    tbl[0] = '{opc: 4'd0, sa: 10'd0, sb: 10'd16, dst: 10'd32, len: 11'd4,
               scalar: 32'h0, a: {F4, F3, F2, F1}, b: {F0_5, F0_5, F0_5, F0_5},
               exp: {F4_5, F3_5, F2_5, F1_5}, exp_err: 1'b0, exp_done: 7};
    tbl[1] = '{opc: 4'd1, sa: 10'd64, sb: 10'd80, dst: 10'd96, len: 11'd2,
               scalar: 32'h0, a: {32'h0, 32'h0, F1, F3}, b: {32'h0, 32'h0, F2, F1},
               exp: {32'h0, 32'h0, FM1, F2}, exp_err: 1'b0, exp_done: 5};
    tbl[2] = '{opc: 4'd2, sa: 10'd128, sb: 10'd144, dst: 10'd160, len: 11'd3,
               scalar: F2, a: {32'h0, 32'h0, FM15, F1}, b: '0,
               exp: {32'h0, 32'h0, FM3, F2}, exp_err: 1'b0, exp_done: 6};
    tbl[3] = '{opc: 4'd0, sa: 10'd200, sb: 10'd210, dst: 10'd220, len: 11'd0,
               scalar: 32'h0, a: '0, b: '0, exp: '0, exp_err: 1'b0, exp_done: 1};
    tbl[4] = '{opc: 4'd7, sa: 10'd200, sb: 10'd210, dst: 10'd220, len: 11'd4,
               scalar: 32'h0, a: '0, b: '0, exp: '0, exp_err: 1'b1, exp_done: 1};
    tbl[5] = '{opc: 4'd0, sa: 10'd1022, sb: 10'd500, dst: 10'd1023, len: 11'd3,
               scalar: 32'h0, a: {32'h0, F3, F2, F1}, b: {32'h0, F1, F1, F1},
               exp: {32'h0, F4, F3, F2}, exp_err: 1'b0, exp_done: 6};

    repeat (2) @(negedge clk);
    chk_rst("rst_hold");
    rst_n = 1'b1;
    @(negedge clk);
    chk_rst("rst_idle");

    foreach (tbl[k]) run(tbl[k]);

    // reset in the middle of a len=8 ADD
    r = tbl[0];
    r.len = 11'd8;
    r.sa = 10'd300; r.sb = 10'd320; r.dst = 10'd340;
    for (int i = 0; i < 8; i++) begin
      mem_a[300 + i] = F1;
      mem_b[320 + i] = F1;
    end
    drive_cmd(r);
    repeat (3) @(negedge clk);
    chk("mid_wr_en", {wr_en, busy}, 2'b11);
    rst_n = 1'b0;
    #1;
    chk_rst("rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    act = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (wr_en || rd_en_a || rd_en_b || op_start || done) act++;
    end
    chk("post_rst_quiet", act, 0);
    chk("post_rst_ready", cmd_ready, 1'b1);
    run(tbl[0]);
    run(tbl[2]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
